// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encoding, ALU codes and mux index helpers
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    function automatic int mux_g(input int nreg);
        return nreg;
    endfunction

    function automatic int mux_din(input int nreg);
        return nreg + 1;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/reg_decoder.sv
// rtl/reg_decoder.sv - register select to one-hot decoder with enable
module reg_decoder #(
    parameter int NREG   = 8,
    parameter int RSEL_W = $clog2(NREG)
) (
    input  logic [RSEL_W-1:0] sel,
    input  logic              en,
    output logic [NREG-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_fsm_gen.sv
// rtl/control_fsm_gen.sv - fetch/decode/execute control FSM; optional mvnz via CONTROL_FSM_MVNZ_EN
module control_fsm_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int RSEL_W = $clog2(NREG),
    parameter int CNT_W  = 16
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iRun,
    input  logic [3+2*RSEL_W-1:0] iIR,
    input  logic                  iGnz,
    output logic [NREG-1:0]       oEn,
    output logic                  oEnA,
    output logic                  oEnG,
    output logic [NREG+1:0]       oMux,
    output logic [2:0]            oALU,
    output logic                  oIR,
    output logic                  oDone,
    output logic                  oIllegal,
    output logic [CNT_W-1:0]      oInstrCnt
);

    localparam int IR_W    = 3 + 2*RSEL_W;
    localparam int MUX_G   = mux_g(NREG);
    localparam int MUX_DIN = mux_din(NREG);

    state_t            state;
    logic [IR_W-1:0]   ir;
    logic [2:0]        opcode;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;
    logic [RSEL_W-1:0] mux_sel;
    logic              mux_reg_on;
    logic              mux_g_on;
    logic              mux_din_on;
    logic              en_on;
    logic [NREG-1:0]   mux_reg;

    assign opcode = ir[IR_W-1 -: 3];
    assign rx     = ir[2*RSEL_W-1 -: RSEL_W];
    assign ry     = ir[RSEL_W-1:0];

`ifndef CONTROL_FSM_MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = iGnz;
`endif

    always_comb begin
        mux_sel    = ry;
        mux_reg_on = 1'b0;
        mux_g_on   = 1'b0;
        mux_din_on = 1'b0;
        en_on      = 1'b0;
        oEnA       = 1'b0;
        oEnG       = 1'b0;
        oALU       = 3'b000;
        oIR        = 1'b0;
        oDone      = 1'b0;
        oIllegal   = 1'b0;
        case (state)
            T0: oIR = iRun;
            T1: begin
                case (opcode)
                    OP_MV: begin
                        mux_reg_on = 1'b1;
                        en_on      = 1'b1;
                        oDone      = 1'b1;
                    end
                    OP_MVI: begin
                        mux_din_on = 1'b1;
                        en_on      = 1'b1;
                        oDone      = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        mux_sel    = rx;
                        mux_reg_on = 1'b1;
                        oEnA       = 1'b1;
                    end
`ifdef CONTROL_FSM_MVNZ_EN
                    OP_MVNZ: begin
                        mux_reg_on = 1'b1;
                        en_on      = iGnz;
                        oDone      = 1'b1;
                    end
`endif
                    default: begin
                        oIllegal = 1'b1;
                        oDone    = 1'b1;
                    end
                endcase
            end
            T2: begin
                mux_reg_on = 1'b1;
                // ALU opcodes are contiguous from add, so the offset is the ALU code
                oALU       = opcode - OP_ADD;
                oEnG       = 1'b1;
            end
            T3: begin
                mux_g_on = 1'b1;
                en_on    = 1'b1;
                oDone    = 1'b1;
            end
            default: ;
        endcase
    end

    reg_decoder #(.NREG(NREG), .RSEL_W(RSEL_W)) u_en_dec (
        .sel    (rx),
        .en     (en_on),
        .onehot (oEn)
    );

    reg_decoder #(.NREG(NREG), .RSEL_W(RSEL_W)) u_mux_dec (
        .sel    (mux_sel),
        .en     (mux_reg_on),
        .onehot (mux_reg)
    );

    always_comb begin
        oMux          = '0;
        oMux[NREG-1:0] = mux_reg;
        oMux[MUX_G]   = mux_g_on;
        oMux[MUX_DIN] = mux_din_on;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= T0;
            ir        <= '0;
            oInstrCnt <= '0;
        end else begin
            if (oDone) oInstrCnt <= oInstrCnt + CNT_W'(1);
            case (state)
                T0: if (iRun) begin
                    ir    <= iIR;
                    state <= T1;
                end
                T1: state <= is_alu_op(opcode) ? T2 : T0;
                T2: state <= T3;
                T3: state <= T0;
                default: state <= T0;
            endcase
        end
    end

endmodule
